// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM encoding and
// a clog2 that never returns zero so counter/index vectors stay legal.
package uart_tx_arbiter_pkg;

    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-facing signal bundle of the arbiter. The arbiter
// uses the slave view; the environment (producers, uart_tx, baud gen) the master view.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = DATA_BITS_DEF
);
    localparam int ID_W = clog2_min1(N_REQ);

    logic                         baud_tick;
    logic [N_REQ-1:0]             req;
    logic [N_REQ*DATA_BITS-1:0]   req_data;
    logic [N_REQ-1:0]             ack;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_busy;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;
    logic                         err;

    modport slave (
        input  baud_tick, req, req_data, tx_busy,
        output ack, tx_start, tx_data, grant_id, busy, err
    );

    modport master (
        output baud_tick, req, req_data, tx_busy,
        input  ack, tx_start, tx_data, grant_id, busy, err
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping modulo N_REQ.
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_idx
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N_REQ]) begin
                o_valid = 1'b1;
                o_idx   = ID_W'((int'(i_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers, with
// start-timeout detection and an optional inter-frame gap in baud ticks.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int GAP_TICKS = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W  = clog2_min1(N_REQ);
    localparam int TO_W  = clog2_min1(TIMEOUT);
    localparam int GAP_W = clog2_min1(GAP_TICKS + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_grant_id;
    logic [DATA_BITS-1:0] r_tx_data;
    logic [TO_W-1:0]      r_to_cnt;
    logic [GAP_W-1:0]     r_gap_cnt;

    logic                 w_pick_vld;
    logic [ID_W-1:0]      w_pick_idx;
    logic                 w_launch;
    logic                 w_timeout;
    logic                 w_gap_done;
    logic [N_REQ-1:0]     w_ack;
    logic                 w_tx_start;
    logic                 w_err;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    // A new frame is only launched while the transmitter is actually idle.
    assign w_launch   = w_pick_vld && !bus.tx_busy;
    assign w_timeout  = !bus.tx_busy && (r_to_cnt == TO_LAST);
    assign w_gap_done = bus.baud_tick && (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = '0;
        w_tx_start  = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_launch) w_state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                w_tx_start        = 1'b1;
                w_ack[r_grant_id] = 1'b1;
                w_state_nxt       = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) w_state_nxt = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (w_gap_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
        end else begin
            // Byte is captured at selection, so a later req drop cannot corrupt it.
            if (r_state == ST_IDLE && w_launch) begin
                r_grant_id <= w_pick_idx;
                r_tx_data  <= bus.req_data[int'(w_pick_idx)*DATA_BITS +: DATA_BITS];
            end

            if (r_state == ST_LAUNCH) begin
                r_ptr    <= (r_grant_id == ID_LAST) ? '0 : r_grant_id + ID_W'(1);
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT_BUSY && !bus.tx_busy && !w_timeout) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            // Ticks only count while already in GAP; the entry-cycle tick is ignored.
            if (r_state != ST_GAP) begin
                r_gap_cnt <= '0;
            end else if (bus.baud_tick) begin
                r_gap_cnt <= w_gap_done ? '0 : r_gap_cnt + GAP_W'(1);
            end
        end
    end

    assign bus.ack      = w_ack;
    assign bus.tx_start = w_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.err      = w_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model
// (10 baud ticks per frame) and a free-running baud tick every 4 clocks.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_BITS(DB)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_BITS(DB), .GAP_TICKS(1), .TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp     = 0;
    int         n_err     = 0;
    int         n_frames  = 0;
    int         gap_ticks = 1;
    bit         uart_en   = 1'b1;
    bit         err_ok    = 1'b0;
    bit         frame_vld = 1'b0;
    bit         prev_busy = 1'b0;
    logic [7:0] launch_data;
    logic [1:0] bcnt;
    int         bits;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt          <= '0;
            bus.baud_tick <= 1'b0;
        end else begin
            bcnt          <= bcnt + 2'd1;
            bus.baud_tick <= (bcnt == 2'd3);
        end
    end

    // uart_tx stand-in: busy from the cycle after tx_start for 10 bit periods.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tx_busy <= 1'b0;
            bits        <= 0;
        end else if (uart_en) begin
            if (!bus.tx_busy && bus.tx_start) begin
                bus.tx_busy <= 1'b1;
                bits        <= 0;
            end else if (bus.tx_busy && bus.baud_tick) begin
                if (bits == 9) bus.tx_busy <= 1'b0;
                bits <= bits + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            frame_vld = 1'b0;
            prev_busy = 1'b0;
            gap_ticks = 1;
        end else begin
            if (bus.tx_start || bus.ack != '0) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: got ack=%b id=%0d, expected no grant", bus.ack, bus.grant_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_start", 32'(bus.tx_start), 32'd1);
                    chk("ack", 32'(bus.ack), 32'(1) << mon_e.id);
                    chk("grant_id", 32'(bus.grant_id), 32'(mon_e.id));
                    chk("tx_data", 32'(bus.tx_data), 32'(mon_e.data));
                    chk("gap_before_frame", 32'(gap_ticks >= 1), 32'd1);
                end
                gap_ticks   = 0;
                launch_data = bus.tx_data;
                frame_vld   = 1'b1;
            end
            if (bus.err && !err_ok) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_err: got err=1, expected 0 (t=%0t)", $time);
            end
            if (!bus.tx_busy && bus.baud_tick) gap_ticks++;
            if (prev_busy && !bus.tx_busy && frame_vld) begin
                chk("tx_data_stable", 32'(bus.tx_data), 32'(launch_data));
                frame_vld = 1'b0;
            end
            prev_busy = bus.tx_busy;
        end
    end

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*DB +: DB] = d;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int c = 0;
        while (n_frames < target && c < 2000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("frames_reached", 32'(n_frames), 32'(target));
    endtask

    task automatic wait_idle();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((bus.busy || bus.tx_busy) && c < 3000);
        chk("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_tx_busy(input logic lvl);
        int c = 0;
        while (bus.tx_busy !== lvl && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("tx_busy_level", 32'(bus.tx_busy), 32'(lvl));
    endtask

    initial begin
        int base;
        int cyc;
        bus.req      = '0;
        bus.req_data = '0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single request, one-cycle latency
        set_data(2, 8'hA5);
        push(2, 8'hA5);
        @(posedge clk);
        #1 bus.req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        chk("t1_latency", 32'(bus.tx_start), 32'd1);
        bus.req = '0;
        wait_idle();
        chk("t1_grant_id_held", 32'(bus.grant_id), 32'd2);
        chk("t1_tx_data_held", 32'(bus.tx_data), 32'hA5);

        // All requesters, pointer from reset: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));
        base = n_frames;
        push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
        @(posedge clk);
        #1 bus.req = 4'b1111;
        wait_frames(base + 5);
        bus.req = '0;
        wait_idle();

        // Wrap: pointer at 1, req 1001 -> 3, 0, 3
        set_data(0, 8'hC0);
        set_data(3, 8'h3C);
        base = n_frames;
        push(3, 8'h3C); push(0, 8'hC0); push(3, 8'h3C);
        @(posedge clk);
        #1 bus.req = 4'b1001;
        wait_frames(base + 3);
        bus.req = '0;
        wait_idle();

        // Start timeout with transmitter never going busy
        uart_en = 1'b0;
        err_ok  = 1'b1;
        set_data(0, 8'h44);
        push(0, 8'h44);
        @(posedge clk);
        #1 bus.req = 4'b0001;
        cyc = 0;
        while (!bus.tx_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_start_seen", 32'(bus.tx_start), 32'd1);
        bus.req = '0;
        cyc = 0;
        while (!bus.err && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_err_delay", 32'(cyc), 32'd64);
        @(negedge clk);
        chk("t4_busy_after_err", 32'(bus.busy), 32'd0);
        chk("t4_err_one_cycle", 32'(bus.err), 32'd0);
        err_ok  = 1'b0;
        uart_en = 1'b1;

        // Reset in WAIT_DONE, then pointer must be back at 0
        set_data(2, 8'h77);
        push(2, 8'h77);
        @(posedge clk);
        #1 bus.req = 4'b0100;
        wait_tx_busy(1'b1);
        bus.req = '0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_ack", 32'(bus.ack), 32'd0);
        chk("t5_tx_start", 32'(bus.tx_start), 32'd0);
        chk("t5_tx_data", 32'(bus.tx_data), 32'd0);
        chk("t5_grant_id", 32'(bus.grant_id), 32'd0);
        chk("t5_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_data(1, 8'h21);
        set_data(3, 8'h23);
        base = n_frames;
        push(1, 8'h21);
        bus.req = 4'b1010;
        wait_frames(base + 1);
        bus.req = '0;
        wait_idle();

        // Late drop after selection; then a request raised during GAP
        set_data(1, 8'h5A);
        base = n_frames;
        push(1, 8'h5A);
        @(posedge clk);
        #1 bus.req = 4'b0010;
        @(posedge clk);
        #1 bus.req = '0;
        set_data(1, 8'hFF);
        wait_tx_busy(1'b1);
        wait_tx_busy(1'b0);
        set_data(0, 8'h0F);
        push(0, 8'h0F);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t6_held_in_gap", 32'(bus.tx_start), 32'd0);
        wait_frames(base + 2);
        bus.req = '0;
        wait_idle();

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
